// File: rtl/fibo_request_arbiter.sv
// Round-robin front end that shares one fibonacci calculator among NUM_REQ clients,
// with operand range screening and a completion timeout on the engine.
module fibo_request_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int MAX_N          = 24,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int ID_W          = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*5-1:0] req_n,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ID_W-1:0]      resp_id,
   output logic [15:0]          resp_data,
   output logic                 resp_err,
   output logic [4:0]           calc_input_s,
   output logic                 calc_begin,
   input  logic [15:0]          calc_fibo_out,
   input  logic                 calc_done,
   output logic                 busy
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [TW-1:0]   timer;

   logic            grant_found_s;
   logic [ID_W-1:0] grant_id_s;
   logic [ID_W-1:0] scan_idx_s;
   logic [4:0]      grant_n_s;
   logic            range_err_s;

   // Round-robin search starting just after the last served requester.
   always_comb begin
      grant_found_s = 1'b0;
      grant_id_s    = '0;
      scan_idx_s    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx_s = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_found_s && req_valid[scan_idx_s]) begin
            grant_found_s = 1'b1;
            grant_id_s    = scan_idx_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Operand of the current winner and its range screen.
   always_comb begin
      grant_n_s = 5'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_s == ID_W'(i)) begin
            grant_n_s = req_n[5*i +: 5];
         end else begin
            grant_n_s = grant_n_s;
         end
      end
      range_err_s = ({27'd0, grant_n_s} > 32'(MAX_N));
   end

   // Accept strobe is only offered while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (reset && (state == ST_IDLE) && grant_found_s) begin
         req_ready[grant_id_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Job sequencer: accept, start the engine, wait for completion, hand back the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         rr_ptr       <= ID_W'(NUM_REQ - 1);
         timer        <= '0;
         resp_valid   <= 1'b0;
         resp_id      <= '0;
         resp_data    <= 16'd0;
         resp_err     <= 1'b0;
         calc_input_s <= 5'd0;
         calc_begin   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         calc_begin <= 1'b0;
         case (state)
            ST_IDLE: begin
               timer <= '0;
               if (grant_found_s) begin
                  resp_id <= grant_id_s;
                  busy    <= 1'b1;
                  if (range_err_s) begin
                     // Out-of-range operands never reach the engine.
                     resp_data  <= 16'd0;
                     resp_err   <= 1'b1;
                     resp_valid <= 1'b1;
                     state      <= ST_RESP;
                  end else begin
                     calc_input_s <= grant_n_s;
                     calc_begin   <= 1'b1;
                     state        <= ST_ISSUE;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_ISSUE: begin
               timer <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (calc_done) begin
                  resp_data  <= calc_fibo_out;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end else if (timer == TIMER_LAST) begin
                  resp_data  <= 16'd0;
                  resp_err   <= 1'b1;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid   <= 1'b0;
                  rr_ptr       <= resp_id;
                  calc_input_s <= 5'd0;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  resp_valid <= 1'b1;
               end
            end
            default: begin
               state        <= ST_IDLE;
               resp_valid   <= 1'b0;
               calc_input_s <= 5'd0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fibo_request_arbiter.sv
// Scoreboard bench for fibo_request_arbiter with a behavioural calculator and
// a spec-level arbitration/response model.
module tb_fibo_request_arbiter;

   localparam int NUM_REQ = 4;
   localparam int MAX_N   = 24;
   localparam int TMO     = 64;
   localparam int ID_W    = $clog2(NUM_REQ);

   logic                 clk;
   logic                 reset;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*5-1:0] req_n;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [ID_W-1:0]      resp_id;
   logic [15:0]          resp_data;
   logic                 resp_err;
   logic [4:0]           calc_input_s;
   logic                 calc_begin;
   logic [15:0]          calc_fibo_out;
   logic                 calc_done;
   logic                 busy;

   fibo_request_arbiter #(.NUM_REQ(NUM_REQ), .MAX_N(MAX_N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_err(resp_err), .calc_input_s(calc_input_s),
      .calc_begin(calc_begin), .calc_fibo_out(calc_fibo_out), .calc_done(calc_done),
      .busy(busy)
   );

   typedef struct {
      int         id;
      logic [15:0] data;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   grant_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   model_idle = 1;
   int   model_rr = NUM_REQ - 1;
   int   beg_due = -1;
   int   exp_valid_cyc = -1;
   int   cur_n = 0;
   int   begin_count = 0;
   int   resp_count = 0;
   int   held = 0;
   int   keep = 0;
   int   rand_en = 0;
   int   rr_mode = 1;
   int   calc_silent = 0;
   int   lat_fixed = 0;
   int   last_id = 0;
   logic [15:0] last_data = 16'd0;
   logic last_err = 1'b0;
   logic [ID_W-1:0] prev_id;
   logic [15:0] prev_data;
   logic prev_err;
   logic [NUM_REQ-1:0] drop_mask = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Calculator convention used here: f(0)=f(1)=1, so f(10)=89.
   function automatic logic [15:0] fib_ref(input int n);
      int a = 1;
      int b = 1;
      int t;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return 16'(a);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Behavioural calculator: answers each begin after a latency, unless silenced.
   initial begin
      int lat;
      int nn;
      calc_done = 1'b0;
      calc_fibo_out = 16'hDEAD;
      forever begin
         @(negedge clk);
         if (calc_begin && reset && calc_silent == 0) begin
            nn = int'(calc_input_s);
            if (lat_fixed != 0) lat = lat_fixed;
            else if ($urandom_range(0, 7) == 0) lat = TMO;
            else lat = $urandom_range(1, 20);
            repeat (lat) @(posedge clk);
            #1;
            calc_done = 1'b1;
            calc_fibo_out = fib_ref(nn);
            exp_valid_cyc = cyc + 1;
            @(posedge clk);
            #1;
            calc_done = 1'b0;
            calc_fibo_out = 16'($urandom);
         end
      end
   end

   // Requester/consumer driver: drops accepted requests, random traffic and resp_ready.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (keep == 0) req_valid = req_valid & ~drop_mask;
         drop_mask = '0;
         case (rr_mode)
            0: resp_ready = ($urandom_range(0, 2) != 0);
            1: resp_ready = 1'b1;
            default: resp_ready = 1'b0;
         endcase
         if (rand_en != 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                  req_n[5*i +: 5] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(25, 31))
                                                                : 5'($urandom_range(0, MAX_N));
                  req_valid[i] = 1'b1;
               end
            end
         end
      end
   end

   // Monitor: predicts grants from the round-robin rule and checks responses from the queue.
   initial begin
      int w;
      int idx;
      int n;
      logic [NUM_REQ-1:0] exp_ready;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            q.delete();
            model_idle = 1;
            model_rr = NUM_REQ - 1;
            beg_due = -1;
            exp_valid_cyc = -1;
            held = 0;
         end else begin
            exp_ready = '0;
            w = -1;
            if (model_idle != 0) begin
               for (int k = 1; k <= NUM_REQ; k++) begin
                  idx = (model_rr + k) % NUM_REQ;
                  if (w < 0 && req_valid[idx]) w = idx;
               end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("busy", 32'(busy), 32'(model_idle == 0));
            chk("calc_begin", 32'(calc_begin), 32'(cyc == beg_due));
            if (calc_begin) begin
               begin_count++;
               chk("calc_input", 32'(calc_input_s), 32'(cur_n));
            end
            if (model_idle != 0) chk("calc_input_idle", 32'(calc_input_s), 32'd0);
            if (resp_valid) begin
               if (held != 0) begin
                  chk("hold_id", 32'(resp_id), 32'(prev_id));
                  chk("hold_data", 32'(resp_data), 32'(prev_data));
                  chk("hold_err", 32'(resp_err), 32'(prev_err));
               end else begin
                  chk("resp_latency", 32'(cyc), 32'(exp_valid_cyc));
                  if (q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL spurious_resp: got id %0d data %0h expected no response", resp_id, resp_data);
                  end else begin
                     e = q[0];
                     chk("resp_id", 32'(resp_id), 32'(e.id));
                     chk("resp_data", 32'(resp_data), 32'(e.data));
                     chk("resp_err", 32'(resp_err), 32'(e.err));
                  end
               end
               prev_id = resp_id;
               prev_data = resp_data;
               prev_err = resp_err;
               if (resp_ready) begin
                  resp_count++;
                  last_id = int'(resp_id);
                  last_data = resp_data;
                  last_err = resp_err;
                  if (q.size() > 0) begin
                     model_rr = q[0].id;
                     q.pop_front();
                  end
                  model_idle = 1;
                  beg_due = -1;
                  held = 0;
               end else begin
                  held = 1;
               end
            end else if (held != 0) begin
               chk("resp_hold_valid", 32'(resp_valid), 32'd1);
               held = 0;
            end
            if (w >= 0) begin
               n = int'(req_n[5*w +: 5]);
               cur_n = n;
               model_idle = 0;
               grant_log.push_back(w);
               if (keep == 0) drop_mask[w] = 1'b1;
               e.id = w;
               if (n > MAX_N) begin
                  e.data = 16'd0;
                  e.err = 1'b1;
                  beg_due = -1;
                  exp_valid_cyc = cyc + 1;
               end else if (calc_silent != 0) begin
                  e.data = 16'd0;
                  e.err = 1'b1;
                  beg_due = cyc + 1;
                  exp_valid_cyc = cyc + 2 + TMO;
               end else begin
                  e.data = fib_ref(n);
                  e.err = 1'b0;
                  beg_due = cyc + 1;
                  exp_valid_cyc = -1;
               end
               q.push_back(e);
            end
         end
      end
   end

   task automatic req(input int i, input int n);
      @(posedge clk);
      #2;
      req_n[5*i +: 5] = 5'(n);
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int k = 0;
      do begin
         @(posedge clk);
         #3;
         k++;
      end while (!(model_idle != 0 && req_valid == '0 && !resp_valid) && k < budget);
      if (k >= budget) begin
         checks++;
         errors++;
         $display("FAIL wait_%s: got still busy expected idle within %0d cycles", nm, budget);
      end
   endtask

   initial begin
      int b0;
      int r0;
      int k;
      reset = 1'b0;
      req_valid = '0;
      req_n = '0;
      resp_ready = 1'b1;
      #12;
      chk("reset_outputs", {req_ready, resp_valid, resp_id, resp_data, resp_err, calc_input_s, calc_begin, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;

      // Four held requests, grants rotate from requester 0.
      keep = 1;
      grant_log.delete();
      @(posedge clk);
      #2;
      req_n = {5'd6, 5'd5, 5'd4, 5'd3};
      req_valid = '1;
      k = 0;
      while (grant_log.size() < 5 && k < 2000) begin
         @(posedge clk);
         #3;
         k++;
      end
      @(posedge clk);
      #2;
      req_valid = '0;
      keep = 0;
      wait_idle(400, "rotation");
      chk("rot_count", 32'(grant_log.size()), 32'd5);
      for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rot_order", 32'(grant_log[i]), 32'(i % NUM_REQ));

      // Single request, fixed calculator latency.
      lat_fixed = 10;
      b0 = begin_count;
      req(0, 10);
      wait_idle(200, "basic");
      chk("basic_begins", 32'(begin_count), 32'(b0 + 1));
      chk("basic_id", 32'(last_id), 32'd0);
      chk("basic_data", 32'(last_data), 32'h0059);
      chk("basic_err", 32'(last_err), 32'd0);
      lat_fixed = 0;

      // Out-of-range operand.
      b0 = begin_count;
      req(2, 25);
      wait_idle(50, "range");
      chk("range_begins", 32'(begin_count), 32'(b0));
      chk("range_id", 32'(last_id), 32'd2);
      chk("range_data", 32'(last_data), 32'd0);
      chk("range_err", 32'(last_err), 32'd1);

      // Calculator never answers, then a late done arrives.
      calc_silent = 1;
      req(1, 12);
      wait_idle(200, "timeout");
      chk("tmo_id", 32'(last_id), 32'd1);
      chk("tmo_data", 32'(last_data), 32'd0);
      chk("tmo_err", 32'(last_err), 32'd1);
      r0 = resp_count;
      @(posedge clk);
      #1;
      calc_done = 1'b1;
      calc_fibo_out = 16'h1234;
      @(posedge clk);
      #1;
      calc_done = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      chk("late_done_no_resp", 32'(resp_count), 32'(r0));
      chk("late_done_not_busy", 32'(busy), 32'd0);
      calc_silent = 0;

      // Back-pressure on the response.
      rr_mode = 2;
      req(3, 5);
      k = 0;
      while (!resp_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("bp_resp_seen", 32'(resp_valid), 32'd1);
      req(0, 7);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_busy", 32'(busy), 32'd1);
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      rr_mode = 1;
      wait_idle(300, "backpressure");

      // Reset in the middle of a wait; discarded job must not answer.
      calc_silent = 1;
      req(1, 9);
      k = 0;
      while (!calc_begin && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("mid_begin_seen", 32'(calc_begin), 32'd1);
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("midreset_outputs", {req_ready, resp_valid, resp_id, resp_data, resp_err, calc_input_s, calc_begin, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      calc_silent = 0;
      grant_log.delete();
      @(posedge clk);
      #2;
      req_n[4:0] = 5'd4;
      req_n[9:5] = 5'd8;
      req_valid[1:0] = 2'b11;
      wait_idle(300, "after_reset");
      chk("post_rst_grants", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() >= 2) begin
         chk("post_rst_first", 32'(grant_log[0]), 32'd0);
         chk("post_rst_second", 32'(grant_log[1]), 32'd1);
      end
      chk("post_rst_last_id", 32'(last_id), 32'd1);

      // Randomised traffic.
      rr_mode = 0;
      rand_en = 1;
      repeat (6000) @(posedge clk);
      rand_en = 0;
      rr_mode = 1;
      wait_idle(3000, "random");
      chk("final_queue_empty", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
